// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//   Multi-cycle multiply/divide controller that produces HI/LO register writes
//   for a MIPS-style pipeline.
//   MULT/MULTU finish in two cycles after acceptance. DIV/DIVU use a 32-step
//   restoring divider, then a sign-fix cycle. MTHI/MTLO write straight through.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active low
//   op_valid  : operation request from EX
//   op_code   : 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   op_a      : rs operand (dividend / multiplicand / MTHI-MTLO source)
//   op_b      : rt operand (divisor / multiplier)
//   flush     : abort the operation in flight (a WB already under way completes)
//   op_ready  : idle and able to accept a request
//   busy      : stall request, high whenever not idle
//   cs_hi     : HI write enable pulse; whi_data is valid with it, else 0
//   cs_lo     : LO write enable pulse; wlo_data is valid with it, else 0
//   div_zero  : one-cycle pulse for DIV/DIVU with a zero divisor
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             op_ready,
    output logic             busy,
    output logic             cs_hi,
    output logic             cs_lo,
    output logic [WIDTH-1:0] whi_data,
    output logic [WIDTH-1:0] wlo_data,
    output logic             div_zero
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;       // multiplicand
    logic [WIDTH-1:0]   b_q, b_d;       // multiplier or divisor magnitude
    logic               sgn_q, sgn_d;   // signed multiply
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    // quo_q starts as the dividend and shifts quotient bits in from the right;
    // rem_q holds the partial remainder. Together they also hold the product.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               cs_hi_q, cs_hi_d;
    logic               cs_lo_q, cs_lo_d;
    logic [WIDTH-1:0]   whi_q, whi_d;
    logic [WIDTH-1:0]   wlo_q, wlo_d;
    logic               dz_q, dz_d;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Datapath helpers (pure combinational functions of the registers).
    always_comb begin
        a_ext   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = a_ext * b_ext;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        quo_fix = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
        rem_fix = a_neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cs_hi_d = 1'b0;
        cs_lo_d = 1'b0;
        whi_d   = '0;
        wlo_d   = '0;
        dz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            a_d     = op_a;
                            b_d     = op_b;
                            sgn_d   = (op_code == OP_MULT);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_neg_d = (op_code == OP_DIV) && op_a[WIDTH-1];
                            b_neg_d = (op_code == OP_DIV) && op_b[WIDTH-1];
                            if (op_b == '0) begin
                                dz_d    = 1'b1;
                                state_d = S_WB;
                            end else begin
                                // Magnitudes; |0x80000000| is still correct
                                // when read back as unsigned.
                                quo_d   = a_neg_d ? -op_a : op_a;
                                b_d     = b_neg_d ? -op_b : op_b;
                                rem_d   = '0;
                                cnt_d   = '0;
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            cs_hi_d = 1'b1;
                            whi_d   = op_a;
                            state_d = S_WB;
                        end
                        OP_MTLO: begin
                            cs_lo_d = 1'b1;
                            wlo_d   = op_a;
                            state_d = S_WB;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    {rem_d, quo_d} = prod;
                    cs_hi_d = 1'b1;
                    cs_lo_d = 1'b1;
                    whi_d   = prod[2*WIDTH-1:WIDTH];
                    wlo_d   = prod[WIDTH-1:0];
                    state_d = S_WB;
                end
            end
            S_DIV: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    // Restoring step: keep the difference only if it did not
                    // go negative. The kept value always fits in WIDTH bits.
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt_q == LAST_ITER) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d   = quo_fix;
                    rem_d   = rem_fix;
                    cs_hi_d = 1'b1;
                    cs_lo_d = 1'b1;
                    whi_d   = rem_fix;
                    wlo_d   = quo_fix;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            cs_hi_q <= 1'b0;
            cs_lo_q <= 1'b0;
            whi_q   <= '0;
            wlo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cs_hi_q <= cs_hi_d;
            cs_lo_q <= cs_lo_d;
            whi_q   <= whi_d;
            wlo_q   <= wlo_d;
            dz_q    <= dz_d;
        end
    end

    assign op_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign cs_hi    = cs_hi_q;
    assign cs_lo    = cs_lo_q;
    assign whi_data = whi_q;
    assign wlo_data = wlo_q;
    assign div_zero = dz_q;

endmodule
